gpio_strobe_out: RTL and testbench

// - Bus-attached byte output port. Drives an 8-bit pin bus plus an update strobe. The rising strobe edge marks a new byte.
// - Producer end of the strobed-GPIO protocol used by the sim console (char out) and exit-code ports.
// - A small FIFO decouples CPU writes from strobe timing, so back-to-back stores do not stall until the FIFO is full.

---
 rtl/gpio_strobe_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/gpio_strobe_out.sv | 160 ++++++++++++++++
 tb/tb_gpio_strobe_out.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_strobe_pkg.sv
// Shared definitions for the strobed-GPIO byte output port: register map,
// STATUS bit layout and the strobe sequencer states.
package gpio_strobe_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_LEVEL_LSB = 3;
    localparam int STAT_LEVEL_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } strobe_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy level. Push while full is
// accepted only when a pop in the same cycle frees the slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= push_data;
        end
    end

    // Flush wins over the pointer/count update; a byte popped in the same
    // cycle has already been read out through pop_data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/gpio_strobe_out.sv
// Bus-attached byte output port: CPU writes are queued in a FIFO and each byte
// is presented on output_pins with a setup / strobe-pulse / hold sequence.
module gpio_strobe_out
    import gpio_strobe_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bus_request,
    input  logic       bus_n_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_data_in,
    output logic       bus_response,
    output logic [7:0] bus_data_out,
    output logic [7:0] output_pins,
    output logic       output_pins_update
);

    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int PH_MAX = max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] PH_SETUP = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_PULSE = PH_W'(PULSE_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_HOLD  = PH_W'(HOLD_CYCLES - 1);

    strobe_state_t   state;
    strobe_state_t   state_next;
    logic [PH_W-1:0] phase_cnt;
    logic [PH_W-1:0] phase_next;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [LW-1:0]   fifo_level;
    logic [7:0]      fifo_data;

    logic            wr_data;
    logic            push_ok;
    logic            access_done;
    logic [7:0]      status_byte;
    logic [7:0]      rd_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (fifo_push),
        .push_data (bus_data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A DATA write to a full FIFO is held off (no response) until the
    // sequencer pops, so the push and the freed slot meet on the same edge.
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign wr_data     = bus_request && !bus_n_we && (bus_addr == REG_DATA);
    assign push_ok     = !fifo_full || fifo_pop;
    assign fifo_push   = wr_data && push_ok;
    assign fifo_flush  = bus_request && !bus_n_we && (bus_addr == REG_CTRL) && bus_data_in[0];
    assign access_done = bus_request && !(wr_data && !push_ok);

    always_comb begin
        status_byte = '0;
        status_byte[STAT_FULL]  = fifo_full;
        status_byte[STAT_EMPTY] = fifo_empty;
        status_byte[STAT_BUSY]  = (state != IDLE);
        status_byte[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    end

    always_comb begin
        rd_data = '0;
        case (bus_addr)
            REG_DATA:   rd_data = output_pins;
            REG_STATUS: rd_data = status_byte;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_response <= 1'b0;
            bus_data_out <= '0;
        end else begin
            bus_response <= access_done;
            bus_data_out <= (access_done && bus_n_we) ? rd_data : '0;
        end
    end

    // Each phase loads phase_cnt with its length minus one and counts down.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SETUP;
                    phase_next = PH_SETUP;
                end
            end
            SETUP: begin
                if (phase_cnt == '0) begin
                    state_next = PULSE;
                    phase_next = PH_PULSE;
                end else begin
                    phase_next = phase_cnt - PH_W'(1);
                end
            end
            PULSE: begin
                if (phase_cnt == '0) begin
                    state_next = HOLD;
                    phase_next = PH_HOLD;
                end else begin
                    phase_next = phase_cnt - PH_W'(1);
                end
            end
            HOLD: begin
                if (phase_cnt == '0) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else begin
                    phase_next = phase_cnt - PH_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            output_pins        <= '0;
            output_pins_update <= 1'b0;
        end else begin
            state              <= state_next;
            phase_cnt          <= phase_next;
            output_pins_update <= (state_next == PULSE);
            if (fifo_pop) begin
                output_pins <= fifo_data;
            end
        end
    end

endmodule

// File: tb/tb_gpio_strobe_out.sv
// Self-checking bench for gpio_strobe_out: directed scenarios plus a randomized
// write/status-read stream checked against a queue-based behavioural model.
module tb_gpio_strobe_out;

    localparam int DEPTH   = 4;
    localparam int SU      = 1;
    localparam int PU      = 2;
    localparam int HO      = 1;
    localparam int SPACING = 1 + SU + PU + HO;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_NONE   = 2'd3;

    logic       clk;
    logic       n_rst;
    logic       bus_request;
    logic       bus_n_we;
    logic [1:0] bus_addr;
    logic [7:0] bus_data_in;
    logic       bus_response;
    logic [7:0] bus_data_out;
    logic [7:0] output_pins;
    logic       output_pins_update;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    gpio_strobe_out #(
        .DEPTH        (DEPTH),
        .SETUP_CYCLES (SU),
        .PULSE_CYCLES (PU),
        .HOLD_CYCLES  (HO)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .bus_request        (bus_request),
        .bus_n_we           (bus_n_we),
        .bus_addr           (bus_addr),
        .bus_data_in        (bus_data_in),
        .bus_response       (bus_response),
        .bus_data_out       (bus_data_out),
        .output_pins        (output_pins),
        .output_pins_update (output_pins_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: logs edge index and presented byte on each rising strobe.
    int         rise_cyc[$];
    logic [7:0] rise_byte[$];
    logic       strobe_prev = 1'b0;

    always @(negedge clk) begin
        if (output_pins_update === 1'b1 && strobe_prev !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_byte.push_back(output_pins);
            $display("console char: %c (0x%02h) at edge %0d", output_pins, output_pins, cyc);
        end
        strobe_prev <= output_pins_update;
    end

    // Behavioural model: a byte queue plus the earliest edge at which the
    // sequencer can take the next byte; each taken byte costs SPACING edges.
    logic [7:0] m_q[$];
    int         m_free_at;
    logic [7:0] m_exp_byte[$];
    int         m_exp_rise[$];

    task automatic model_reset();
        m_q.delete();
        m_exp_byte.delete();
        m_exp_rise.delete();
        m_free_at = 0;
    endtask

    task automatic model_step(input int e, input bit wr, input logic [7:0] d,
                              output bit pushed, output logic [7:0] status);
        int sz;
        bit take;
        bit busy;
        sz     = m_q.size();
        busy   = (e < m_free_at);
        take   = !busy && (sz > 0);
        status = {5'(sz), busy, (sz == 0), (sz == DEPTH)};
        if (take) begin
            m_exp_byte.push_back(m_q.pop_front());
            m_exp_rise.push_back(e + SU);
            m_free_at = e + SPACING;
        end
        pushed = wr && ((sz < DEPTH) || take);
        if (pushed) m_q.push_back(d);
    endtask

    task automatic log_clear();
        rise_cyc.delete();
        rise_byte.delete();
    endtask

    // One bus access; waited = edges until response, -1 on timeout.
    task automatic bus_op(input logic n_we, input logic [1:0] addr, input logic [7:0] data,
                          output logic [7:0] rdata, output int waited);
        bus_request = 1'b1;
        bus_n_we    = n_we;
        bus_addr    = addr;
        bus_data_in = data;
        waited      = 0;
        rdata       = '0;
        while (1) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus_response === 1'b1) begin
                rdata = bus_data_out;
                break;
            end
            if (waited >= 30) begin
                waited      = -1;
                bus_request = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus_request = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        int w;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (output_pins !== 8'h00) begin errors++; $display("FAIL reset_pins: got %02h want 00", output_pins); end
        checks++; if (output_pins_update !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", output_pins_update); end
        checks++; if (bus_response !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", bus_response); end
        checks++; if (bus_data_out !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h want 00", bus_data_out); end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        log_clear();
        idle(20);
        checks++; if (rise_cyc.size() != 0) begin errors++; $display("FAIL reset_idle_strobes: got %0d want 0", rise_cyc.size()); end
        checks++; if (output_pins !== 8'h00) begin errors++; $display("FAIL reset_idle_pins: got %02h want 00", output_pins); end
        bus_op(1'b1, A_STATUS, 8'h00, rd, w);
        bus_request = 1'b0;
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL reset_status: got %02h want 02", rd); end
        checks++; if (w != 1) begin errors++; $display("FAIL reset_status_latency: got %0d want 1", w); end
    endtask

    task automatic test_single();
        logic [7:0] rd;
        int w;
        int c0;
        log_clear();
        c0 = cyc;
        bus_op(1'b0, A_DATA, 8'h41, rd, w);
        bus_request = 1'b0;
        checks++; if (w != 1) begin errors++; $display("FAIL single_ack: got %0d want 1", w); end
        @(posedge clk); #1;
        checks++; if (output_pins !== 8'h41) begin errors++; $display("FAIL single_pins_c2: got %02h want 41", output_pins); end
        checks++; if (output_pins_update !== 1'b0) begin errors++; $display("FAIL single_strobe_c2: got %b want 0", output_pins_update); end
        @(posedge clk); #1;
        checks++; if (output_pins_update !== 1'b1) begin errors++; $display("FAIL single_strobe_c3: got %b want 1", output_pins_update); end
        @(posedge clk); #1;
        checks++; if (output_pins_update !== 1'b1) begin errors++; $display("FAIL single_strobe_c4: got %b want 1", output_pins_update); end
        @(posedge clk); #1;
        checks++; if (output_pins_update !== 1'b0) begin errors++; $display("FAIL single_strobe_c5: got %b want 0", output_pins_update); end
        idle(10);
        checks++; if (rise_cyc.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", rise_cyc.size()); end
        if (rise_cyc.size() > 0) begin
            checks++; if (rise_byte[0] !== 8'h41) begin errors++; $display("FAIL single_byte: got %02h want 41", rise_byte[0]); end
            checks++; if (rise_cyc[0] != c0 + 3) begin errors++; $display("FAIL single_rise_edge: got %0d want %0d", rise_cyc[0], c0 + 3); end
        end
        checks++; if (output_pins !== 8'h41) begin errors++; $display("FAIL single_pins_hold: got %02h want 41", output_pins); end
    endtask

    // Six writes: the FIFO fills after the fifth, the sixth waits for the
    // second pop and lands together with it.
    task automatic test_back_to_back();
        logic [7:0] rd;
        int w[6];
        int exp_w[6] = '{1, 1, 1, 1, 1, 2};
        int c0;
        log_clear();
        c0 = cyc;
        for (int i = 0; i < 6; i++) bus_op(1'b0, A_DATA, 8'h30 + 8'(i), rd, w[i]);
        bus_request = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (w[i] != exp_w[i]) begin errors++; $display("FAIL b2b_ack[%0d]: got %0d want %0d", i, w[i], exp_w[i]); end
        end
        idle(40);
        checks++; if (rise_cyc.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", rise_cyc.size()); end
        if (rise_cyc.size() == 6) begin
            checks++; if (rise_cyc[0] != c0 + 3) begin errors++; $display("FAIL b2b_first_rise: got %0d want %0d", rise_cyc[0], c0 + 3); end
            for (int i = 0; i < 6; i++) begin
                checks++; if (rise_byte[i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL b2b_byte[%0d]: got %02h want %02h", i, rise_byte[i], 8'h30 + 8'(i)); end
                if (i > 0) begin
                    checks++; if (rise_cyc[i] - rise_cyc[i-1] != SPACING) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, rise_cyc[i] - rise_cyc[i-1], SPACING); end
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] rd;
        int w;
        // Flush while the first byte is being strobed.
        log_clear();
        bus_op(1'b0, A_DATA, 8'h50, rd, w);
        bus_request = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) bus_op(1'b0, A_DATA, 8'h50 + 8'(i), rd, w);
        bus_op(1'b0, A_CTRL, 8'h01, rd, w);
        bus_request = 1'b0;
        checks++; if (w != 1) begin errors++; $display("FAIL flush_ack: got %0d want 1", w); end
        idle(20);
        checks++; if (rise_cyc.size() != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", rise_cyc.size()); end
        if (rise_cyc.size() > 0) begin
            checks++; if (rise_byte[0] !== 8'h50) begin errors++; $display("FAIL flush_byte: got %02h want 50", rise_byte[0]); end
        end
        bus_op(1'b1, A_STATUS, 8'h00, rd, w);
        bus_request = 1'b0;
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL flush_status: got %02h want 02", rd); end
        // Flush on the very edge the sequencer takes the next byte.
        log_clear();
        for (int i = 0; i < 4; i++) bus_op(1'b0, A_DATA, 8'h60 + 8'(i), rd, w);
        idle(2);
        bus_op(1'b0, A_CTRL, 8'h01, rd, w);
        bus_request = 1'b0;
        idle(20);
        checks++; if (rise_cyc.size() != 2) begin errors++; $display("FAIL flushpop_count: got %0d want 2", rise_cyc.size()); end
        if (rise_cyc.size() == 2) begin
            checks++; if (rise_byte[0] !== 8'h60 || rise_byte[1] !== 8'h61) begin
                errors++; $display("FAIL flushpop_bytes: got %02h %02h want 60 61", rise_byte[0], rise_byte[1]);
            end
        end
        bus_op(1'b1, A_STATUS, 8'h00, rd, w);
        bus_request = 1'b0;
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL flushpop_status: got %02h want 02", rd); end
    endtask

    task automatic test_readback();
        logic [7:0] rd;
        int w;
        log_clear();
        bus_op(1'b0, A_DATA, 8'h7F, rd, w);
        idle(10);
        bus_op(1'b1, A_DATA, 8'h00, rd, w);
        bus_request = 1'b0;
        checks++; if (rd !== 8'h7F) begin errors++; $display("FAIL read_data: got %02h want 7f", rd); end
        checks++; if (w != 1) begin errors++; $display("FAIL read_data_latency: got %0d want 1", w); end
        @(posedge clk); #1;
        checks++; if (bus_data_out !== 8'h00) begin errors++; $display("FAIL read_data_idle_zero: got %02h want 00", bus_data_out); end
        bus_op(1'b1, A_NONE, 8'h00, rd, w);
        bus_request = 1'b0;
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL read_addr3: got %02h want 00", rd); end
        checks++; if (w != 1) begin errors++; $display("FAIL read_addr3_latency: got %0d want 1", w); end
        bus_op(1'b0, A_NONE, 8'hFF, rd, w);
        bus_request = 1'b0;
        checks++; if (w != 1) begin errors++; $display("FAIL write_addr3_ack: got %0d want 1", w); end
        idle(10);
        checks++; if (rise_cyc.size() != 1) begin errors++; $display("FAIL readback_count: got %0d want 1", rise_cyc.size()); end
        checks++; if (output_pins !== 8'h7F) begin errors++; $display("FAIL readback_pins: got %02h want 7f", output_pins); end
    endtask

    task automatic test_random();
        int         gap;
        int         waited;
        bit         is_rd;
        bit         pushed;
        bit         exp_resp;
        logic [7:0] d;
        logic [7:0] st;
        int         n;
        log_clear();
        model_reset();
        for (int i = 0; i < 60; i++) begin
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                bus_request = 1'b0;
                @(posedge clk); #1;
                model_step(cyc, 1'b0, 8'h00, pushed, st);
            end
            is_rd       = ($urandom_range(0, 3) == 0);
            d           = 8'($urandom);
            bus_request = 1'b1;
            bus_n_we    = is_rd;
            bus_addr    = is_rd ? A_STATUS : A_DATA;
            bus_data_in = d;
            waited      = 0;
            do begin
                @(posedge clk); #1;
                waited++;
                model_step(cyc, !is_rd, d, pushed, st);
                exp_resp = is_rd || pushed;
                checks++; if (bus_response !== exp_resp) begin
                    errors++; $display("FAIL rand_resp[%0d]: got %b want %b at edge %0d", i, bus_response, exp_resp, cyc);
                end
                if (is_rd) begin
                    checks++; if (bus_data_out !== st) begin
                        errors++; $display("FAIL rand_status[%0d]: got %02h want %02h", i, bus_data_out, st);
                    end
                end
            end while (!exp_resp && waited < 20);
        end
        bus_request = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            model_step(cyc, 1'b0, 8'h00, pushed, st);
        end
        checks++; if (rise_cyc.size() != m_exp_rise.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", rise_cyc.size(), m_exp_rise.size());
        end
        n = (rise_cyc.size() < m_exp_rise.size()) ? rise_cyc.size() : m_exp_rise.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (rise_byte[i] !== m_exp_byte[i] || rise_cyc[i] != m_exp_rise[i]) begin
                errors++; $display("FAIL rand_strobe[%0d]: got %02h@%0d want %02h@%0d", i, rise_byte[i], rise_cyc[i], m_exp_byte[i], m_exp_rise[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        int w;
        log_clear();
        for (int i = 0; i < 3; i++) bus_op(1'b0, A_DATA, 8'h11 + 8'(i), rd, w);
        bus_request = 1'b0;
        checks++; if (output_pins_update !== 1'b1) begin errors++; $display("FAIL rstmid_in_pulse: got %b want 1", output_pins_update); end
        bus_request = 1'b1;
        bus_n_we    = 1'b1;
        bus_addr    = A_STATUS;
        #2;
        n_rst = 1'b0;
        #1;
        checks++; if (output_pins_update !== 1'b0) begin errors++; $display("FAIL rstmid_strobe_drop: got %b want 0", output_pins_update); end
        checks++; if (output_pins !== 8'h00) begin errors++; $display("FAIL rstmid_pins: got %02h want 00", output_pins); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++; if (bus_response !== 1'b0) begin errors++; $display("FAIL rstmid_resp[%0d]: got %b want 0", k, bus_response); end
        end
        bus_request = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        log_clear();
        idle(20);
        checks++; if (rise_cyc.size() != 0) begin errors++; $display("FAIL rstmid_strobes: got %0d want 0", rise_cyc.size()); end
        bus_op(1'b1, A_STATUS, 8'h00, rd, w);
        bus_request = 1'b0;
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL rstmid_status: got %02h want 02", rd); end
    endtask

    initial begin
        n_rst       = 1'b0;
        bus_request = 1'b0;
        bus_n_we    = 1'b1;
        bus_addr    = 2'd0;
        bus_data_in = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_readback();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
